// File: rtl/fm_ram_write_ctrl.sv
// fm_ram_write_ctrl: write-side initiator for the float16 feature-map RAM.
// Takes PARA_Y-wide beats from the conv datapath and turns each one into a
// single-cycle plain write (first input-channel pass) or a two-cycle add-write
// followed by a one-cycle gap (accumulate passes). An optional zero-fill strobe
// clears an address range before the first beat of a pass.
module fm_ram_write_ctrl #(
  parameter int DATA_WIDTH       = 16,
  parameter int PARA_Y           = 3,
  parameter int WRITE_ADDR_WIDTH = 12,
  parameter int CNT_WIDTH        = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         add_mode,
  input  logic                         zero_en,
  input  logic [WRITE_ADDR_WIDTH-1:0]  zero_start_in,
  input  logic [WRITE_ADDR_WIDTH-1:0]  zero_end_in,
  input  logic [WRITE_ADDR_WIDTH-1:0]  base_addr,
  input  logic [CNT_WIDTH-1:0]         beat_count,
  input  logic                         in_valid,
  input  logic [PARA_Y*DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         ena_zero_w,
  output logic [WRITE_ADDR_WIDTH-1:0]  zero_start_addr,
  output logic [WRITE_ADDR_WIDTH-1:0]  zero_end_addr,
  output logic                         ena_w,
  output logic                         ena_add_write,
  output logic [WRITE_ADDR_WIDTH-1:0]  addr_write,
  output logic [PARA_Y*DATA_WIDTH-1:0] din,
  input  logic                         write_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         err_handshake
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZERO,
    S_ACCEPT,
    S_PLAIN,
    S_ADD1,
    S_ADD2,
    S_GAP,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // Pass configuration captured on an accepted start
  logic                         add_mode_q,   add_mode_d;
  logic [WRITE_ADDR_WIDTH-1:0]  zero_start_q, zero_start_d;
  logic [WRITE_ADDR_WIDTH-1:0]  zero_end_q,   zero_end_d;
  logic [WRITE_ADDR_WIDTH-1:0]  base_q,       base_d;
  logic [CNT_WIDTH-1:0]         count_q,      count_d;

  // Per-beat progress and the write word presented to the RAM
  logic [CNT_WIDTH-1:0]         beat_idx_q,   beat_idx_d;
  logic [WRITE_ADDR_WIDTH-1:0]  addr_q,       addr_d;
  logic [PARA_Y*DATA_WIDTH-1:0] din_q,        din_d;
  logic                         err_q,        err_d;

  logic                         last_beat;

  // The beat currently being written is the final one of the pass
  assign last_beat = (beat_idx_q == (count_q - CNT_WIDTH'(1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: zero-fill first if requested, then one beat at a time
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (zero_en) begin
            state_d = S_ZERO;
          end else if (beat_count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end
      S_ZERO: begin
        state_d = (count_q == '0) ? S_DONE : S_ACCEPT;
      end
      S_ACCEPT: begin
        if (in_valid) begin
          state_d = add_mode_q ? S_ADD1 : S_PLAIN;
        end
      end
      S_PLAIN: begin
        state_d = last_beat ? S_DONE : S_ACCEPT;
      end
      S_ADD1: begin
        state_d = S_ADD2;
      end
      S_ADD2: begin
        state_d = S_GAP;
      end
      S_GAP: begin
        state_d = last_beat ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath registers: configuration, beat index, write word, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_mode_q   <= 1'b0;
      zero_start_q <= '0;
      zero_end_q   <= '0;
      base_q       <= '0;
      count_q      <= '0;
      beat_idx_q   <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      add_mode_q   <= add_mode_d;
      zero_start_q <= zero_start_d;
      zero_end_q   <= zero_end_d;
      base_q       <= base_d;
      count_q      <= count_d;
      beat_idx_q   <= beat_idx_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      err_q        <= err_d;
    end
  end

  // Datapath next values; a start while busy never reaches the latch path
  always_comb begin
    add_mode_d   = add_mode_q;
    zero_start_d = zero_start_q;
    zero_end_d   = zero_end_q;
    base_d       = base_q;
    count_d      = count_q;
    beat_idx_d   = beat_idx_q;
    addr_d       = addr_q;
    din_d        = din_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          add_mode_d   = add_mode;
          zero_start_d = zero_start_in;
          zero_end_d   = zero_end_in;
          base_d       = base_addr;
          count_d      = beat_count;
          beat_idx_d   = '0;
          err_d        = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          din_d  = in_data;
          addr_d = base_q + WRITE_ADDR_WIDTH'(beat_idx_q);
        end
      end
      S_PLAIN: begin
        beat_idx_d = beat_idx_q + CNT_WIDTH'(1);
      end
      S_GAP: begin
        beat_idx_d = beat_idx_q + CNT_WIDTH'(1);
        if (!write_ready) begin
          err_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Output decode: strobes are a pure function of state, so they drop with reset
  always_comb begin
    in_ready      = 1'b0;
    ena_zero_w    = 1'b0;
    ena_w         = 1'b0;
    ena_add_write = 1'b0;
    done          = 1'b0;
    busy          = (state_q != S_IDLE);
    case (state_q)
      S_ZERO: begin
        ena_zero_w = 1'b1;
      end
      S_ACCEPT: begin
        in_ready = 1'b1;
      end
      S_PLAIN: begin
        ena_w = 1'b1;
      end
      S_ADD1, S_ADD2: begin
        ena_w         = 1'b1;
        ena_add_write = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign zero_start_addr = zero_start_q;
  assign zero_end_addr   = zero_end_q;
  assign addr_write      = addr_q;
  assign din             = din_q;
  assign err_handshake   = err_q;

endmodule

// File: tb/tb_fm_ram_write_ctrl.sv
// Bench for fm_ram_write_ctrl: a table of passes driven through one task, a
// behavioural FM RAM with float16 add-write, and a protocol monitor.
module tb_fm_ram_write_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        add_mode;
  logic        zero_en;
  logic [11:0] zero_start_in;
  logic [11:0] zero_end_in;
  logic [11:0] base_addr;
  logic [11:0] beat_count;
  logic        in_valid;
  logic [47:0] in_data;
  logic        in_ready;
  logic        ena_zero_w;
  logic [11:0] zero_start_addr;
  logic [11:0] zero_end_addr;
  logic        ena_w;
  logic        ena_add_write;
  logic [11:0] addr_write;
  logic [47:0] din;
  logic        write_ready;
  logic        busy;
  logic        done;
  logic        err_handshake;

  int errors = 0;
  int checks = 0;

  fm_ram_write_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .add_mode        (add_mode),
    .zero_en         (zero_en),
    .zero_start_in   (zero_start_in),
    .zero_end_in     (zero_end_in),
    .base_addr       (base_addr),
    .beat_count      (beat_count),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .ena_zero_w      (ena_zero_w),
    .zero_start_addr (zero_start_addr),
    .zero_end_addr   (zero_end_addr),
    .ena_w           (ena_w),
    .ena_add_write   (ena_add_write),
    .addr_write      (addr_write),
    .din             (din),
    .write_ready     (write_ready),
    .busy            (busy),
    .done            (done),
    .err_handshake   (err_handshake)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          addMode;
    bit          zeroEn;
    logic [11:0] zeroStart;
    logic [11:0] zeroEnd;
    logic [11:0] base;
    logic [11:0] count;
    logic [15:0] preload;
    logic [15:0] elem;
    bit          noReady;
    int          stall;
    bit          midStart;
    int          expLatency;
    logic [15:0] expWord;
    bit          expErr;
    string       name;
  } vec_t;

  // float16 helpers for normal numbers, enough for the RAM model's add-write
  function automatic real halfToReal(input logic [15:0] h);
    real r;
    int  e;
    if (h[14:0] == 15'd0) return 0.0;
    r = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] realToHalf(input real r);
    logic [15:0] h;
    real a;
    int  e;
    int  m;
    if (r == 0.0) return 16'h0000;
    h = 16'h0000;
    h[15] = (r < 0.0);
    a = (r < 0.0) ? -r : r;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = int'((a - 1.0) * 1024.0);
    h[14:10] = e[4:0];
    h[9:0]   = m[9:0];
    return h;
  endfunction

  // Beat payload: distinct elements for plain passes, a uniform value for add passes
  function automatic logic [47:0] payload(input logic [15:0] elem, input bit addMode, input int i);
    if (addMode) return {elem, elem, elem};
    return {elem + 16'(3 * i + 2), elem + 16'(3 * i + 1), elem + 16'(3 * i)};
  endfunction

  // Behavioural FM RAM: plain write, zero-fill, and add-write completing on its 2nd cycle
  logic [47:0] ram [0:4095];
  logic        preloadReq = 1'b0;
  logic [15:0] preloadWord = 16'h0000;
  bit          ramNoReady = 1'b0;
  int          addCnt = 0;

  always @(posedge clk) begin
    if (preloadReq) begin
      for (int a = 0; a < 4096; a++) ram[a] = {preloadWord, preloadWord, preloadWord};
    end
    if (ena_zero_w) begin
      for (int a = int'(zero_start_addr); a < int'(zero_end_addr); a++) ram[a] = 48'd0;
    end
    if (!rst_n) begin
      addCnt = 0;
      write_ready <= 1'b0;
    end else if (ena_w && !ena_add_write) begin
      ram[addr_write] = din;
      addCnt = 0;
      write_ready <= 1'b0;
    end else if (ena_w && ena_add_write) begin
      addCnt++;
      if (addCnt == 2) begin
        for (int j = 0; j < 3; j++) begin
          ram[addr_write][16*j +: 16] =
            realToHalf(halfToReal(ram[addr_write][16*j +: 16]) + halfToReal(din[16*j +: 16]));
        end
        write_ready <= !ramNoReady;
      end else begin
        if (addCnt > 2) addCnt = 1;
        write_ready <= 1'b0;
      end
    end else begin
      addCnt = 0;
      write_ready <= 1'b0;
    end
  end

  // Protocol monitor: logs write transactions and zero strobes, counts rule breaks
  logic [11:0] txAddr [$];
  logic [47:0] txDin  [$];
  logic [11:0] zeroS  [$];
  logic [11:0] zeroE  [$];
  int          violations = 0;
  int          enaWCycles = 0;
  int          doneSeen = 0;
  bit          curAddMode = 1'b0;
  bit          prevEnaW = 1'b0;
  int          runLen = 0;
  logic [11:0] runAddr;
  logic [47:0] runDin;

  always @(negedge clk) begin
    if (ena_w) begin
      enaWCycles++;
      if (!prevEnaW) begin
        txAddr.push_back(addr_write);
        txDin.push_back(din);
        runLen  = 1;
        runAddr = addr_write;
        runDin  = din;
      end else begin
        runLen++;
        if (addr_write != runAddr || din != runDin) violations++;
      end
      if (runLen > (ena_add_write ? 2 : 1)) violations++;
      if (ena_add_write != curAddMode) violations++;
    end
    if ((int'(ena_w) + int'(ena_zero_w) + int'(in_ready)) > 1) violations++;
    if (ena_add_write && !ena_w) violations++;
    if (ena_zero_w) begin
      zeroS.push_back(zero_start_addr);
      zeroE.push_back(zero_end_addr);
    end
    if (done) doneSeen++;
    prevEnaW = ena_w;
  end

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Run one pass from the table and compare everything it should have produced
  task automatic applyStimulus(input vec_t v);
    int qa;
    int qz;
    int vb;
    int wb;
    int cyc;
    int sent;
    int latency;
    int stallReady;
    int n;
    logic errAtDone;
    logic [11:0] a;
    logic [47:0] expWordVec;

    @(negedge clk);
    preloadWord = v.preload;
    preloadReq  = 1'b1;
    ramNoReady  = v.noReady;
    curAddMode  = v.addMode;
    @(negedge clk);
    preloadReq = 1'b0;
    qa = txAddr.size();
    qz = zeroS.size();
    vb = violations;
    wb = enaWCycles;
    start         = 1'b1;
    add_mode      = v.addMode;
    zero_en       = v.zeroEn;
    zero_start_in = v.zeroStart;
    zero_end_in   = v.zeroEnd;
    base_addr     = v.base;
    beat_count    = v.count;
    in_valid      = 1'b0;
    @(negedge clk);
    // Scramble configuration after the start edge: only latched values may matter
    add_mode      = ~v.addMode;
    zero_en       = ~v.zeroEn;
    zero_start_in = ~v.zeroStart;
    zero_end_in   = ~v.zeroEnd;
    base_addr     = ~v.base;
    beat_count    = 12'hFFF;
    checkOutput({v.name, " busyAfterStart"}, 64'(busy), 64'd1);
    sent = 0;
    latency = -1;
    stallReady = 0;
    errAtDone = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      start = (v.midStart && cyc == 3);
      if (done) begin
        latency   = cyc;
        errAtDone = err_handshake;
        break;
      end
      if (cyc <= v.stall && in_ready) stallReady++;
      if (cyc > v.stall && sent < int'(v.count)) begin
        in_valid = 1'b1;
        in_data  = payload(v.elem, v.addMode, sent);
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
        in_data  = {16'($urandom), 32'($urandom)};
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (latency < 0) begin
      errors++;
      $display("[TB] FAIL %s timeout: no done within 200 cycles", v.name);
    end
    checkOutput({v.name, " latency"}, 64'(latency), 64'(v.expLatency));
    checkOutput({v.name, " errAtDone"}, 64'(errAtDone), 64'(v.expErr));
    @(negedge clk);
    checkOutput({v.name, " idleAfterDone"}, {62'd0, busy, done}, 64'd0);

    n = txAddr.size() - qa;
    checkOutput({v.name, " writeCount"}, 64'(n), 64'(v.count));
    for (int i = 0; i < n && i < int'(v.count); i++) begin
      a = v.base + 12'(i);
      checkOutput($sformatf("%s addr%0d", v.name, i), 64'(txAddr[qa + i]), 64'(a));
      checkOutput($sformatf("%s din%0d", v.name, i), 64'(txDin[qa + i]),
                  64'(payload(v.elem, v.addMode, i)));
      expWordVec = v.addMode ? {v.expWord, v.expWord, v.expWord} : payload(v.elem, 1'b0, i);
      checkOutput($sformatf("%s ram%0d", v.name, i), 64'(ram[a]), 64'(expWordVec));
    end
    checkOutput({v.name, " enaWCycles"}, 64'(enaWCycles - wb),
                64'(int'(v.count) * (v.addMode ? 2 : 1)));
    checkOutput({v.name, " zeroStrobes"}, 64'(zeroS.size() - qz), 64'(v.zeroEn));
    if (v.zeroEn && zeroS.size() > qz) begin
      checkOutput({v.name, " zeroRange"}, {40'd0, zeroS[qz], zeroE[qz]},
                  {40'd0, v.zeroStart, v.zeroEnd});
    end
    checkOutput({v.name, " protocol"}, 64'(violations - vb), 64'd0);
    if (v.stall > 0) checkOutput({v.name, " readyDuringStall"}, 64'(stallReady), 64'(v.stall));
  endtask

  vec_t vecs [8];
  vec_t cleanVec;
  int   addSeen;

  initial begin
    //            add zero zs      ze      base      cnt    preload   elem      noRdy stall mid lat word      err name
    vecs[0] = '{1'b0, 1'b0, 12'd0, 12'd0, 12'd4,    12'd3, 16'h0000, 16'h0100, 1'b0, 0, 1'b0, 7,  16'h0000, 1'b0, "plainT1"};
    vecs[1] = '{1'b1, 1'b0, 12'd0, 12'd0, 12'd10,   12'd2, 16'h3C00, 16'h4000, 1'b0, 0, 1'b0, 9,  16'h4200, 1'b0, "addT2"};
    vecs[2] = '{1'b0, 1'b1, 12'd0, 12'd9, 12'd0,    12'd0, 16'h0000, 16'h0000, 1'b0, 0, 1'b0, 2,  16'h0000, 1'b0, "zeroCnt0"};
    vecs[3] = '{1'b1, 1'b0, 12'd0, 12'd0, 12'd30,   12'd1, 16'h3C00, 16'h4000, 1'b1, 0, 1'b0, 5,  16'h4200, 1'b1, "addNoReady"};
    vecs[4] = '{1'b0, 1'b0, 12'd0, 12'd0, 12'd50,   12'd2, 16'h0000, 16'h0200, 1'b0, 5, 1'b1, 10, 16'h0000, 1'b0, "stallBusy"};
    vecs[5] = '{1'b1, 1'b1, 12'd60, 12'd64, 12'd60, 12'd2, 16'h3C00, 16'h4000, 1'b0, 0, 1'b0, 10, 16'h4000, 1'b0, "zeroThenAdd"};
    vecs[6] = '{1'b0, 1'b0, 12'd0, 12'd0, 12'd4094, 12'd3, 16'h0000, 16'h0300, 1'b0, 0, 1'b0, 7,  16'h0000, 1'b0, "wrapPlain"};
    vecs[7] = '{1'b0, 1'b1, 12'd9, 12'd3, 12'd70,   12'd1, 16'h0000, 16'h0400, 1'b0, 0, 1'b0, 4,  16'h0000, 1'b0, "zeroInverted"};
    cleanVec = '{1'b1, 1'b0, 12'd0, 12'd0, 12'd80,  12'd1, 16'h3C00, 16'h4000, 1'b0, 0, 1'b0, 5,  16'h4200, 1'b0, "afterReset"};

    rst_n = 1'b0;
    start = 1'b0;
    add_mode = 1'b0;
    zero_en = 1'b0;
    zero_start_in = '0;
    zero_end_in = '0;
    base_addr = '0;
    beat_count = '0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetStrobes", {58'd0, in_ready, ena_zero_w, ena_w, ena_add_write, busy, done}, 64'd0);
    checkOutput("resetAddrDin", {4'd0, addr_write, din}, 64'd0);
    checkOutput("resetZeroErr", {39'd0, zero_start_addr, zero_end_addr, err_handshake}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Reset in the second add-write cycle: outputs drop at once and no done follows
    @(negedge clk);
    preloadWord = 16'h3C00;
    preloadReq = 1'b1;
    ramNoReady = 1'b0;
    curAddMode = 1'b1;
    @(negedge clk);
    preloadReq = 1'b0;
    start = 1'b1;
    add_mode = 1'b1;
    zero_en = 1'b0;
    base_addr = 12'd20;
    beat_count = 12'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = {16'h4000, 16'h4000, 16'h4000};
    addSeen = 0;
    for (int c = 0; c < 20 && addSeen < 2; c++) begin
      @(negedge clk);
      addSeen = ena_add_write ? addSeen + 1 : 0;
    end
    checkOutput("midAdd2Reached", 64'(addSeen), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncResetStrobes", {58'd0, in_ready, ena_zero_w, ena_w, ena_add_write, busy, done}, 64'd0);
    checkOutput("asyncResetAddrDin", {4'd0, addr_write, din}, 64'd0);
    in_valid = 1'b0;
    doneSeen = 0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("noDoneAfterReset", 64'(doneSeen), 64'd0);
    applyStimulus(cleanVec);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
